// File: rtl/id_stage_pipe_if.sv
// ID-stage bundle: the fetch->ID handshake, the writeback port, flush/ex_ready
// from EX, and the registered ID/EX outputs.
//   master : the upstream/downstream environment (fetch, WB, EX)
//   slave  : the decode stage itself
interface id_stage_pipe_if #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32
);
  // fetch -> ID
  logic                 in_valid;
  logic                 in_ready;
  logic [INSTR_LEN-1:0] instruction;
  // writeback
  logic                 wb_en;
  logic [4:0]           wb_reg;
  logic [WORD-1:0]      wb_data;
  // EX control
  logic                 flush;
  logic                 ex_ready;
  // ID/EX outputs
  logic                 out_valid;
  logic [10:0]          opcode;
  logic [4:0]           rd_num;
  logic [4:0]           rn_num;
  logic [4:0]           rm_num;
  logic [WORD-1:0]      read_data1;
  logic [WORD-1:0]      read_data2;
  logic [WORD-1:0]      imm;
  logic                 reg2_loc;
  logic                 uncondbranch;
  logic                 branch;
  logic                 mem_read;
  logic                 mem_to_reg;
  logic                 mem_write;
  logic                 alu_src;
  logic                 reg_write;
  logic [1:0]           alu_op;
  logic                 hazard;

  modport master (
    output in_valid, instruction, wb_en, wb_reg, wb_data, flush, ex_ready,
    input  in_ready, out_valid, opcode, rd_num, rn_num, rm_num,
           read_data1, read_data2, imm, reg2_loc, uncondbranch, branch,
           mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, hazard
  );

  modport slave (
    input  in_valid, instruction, wb_en, wb_reg, wb_data, flush, ex_ready,
    output in_ready, out_valid, opcode, rd_num, rn_num, rm_num,
           read_data1, read_data2, imm, reg2_loc, uncondbranch, branch,
           mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op, hazard
  );
endinterface

// File: rtl/id_stage_pipe.sv
// Pipelined LEGv8 decode stage: field parser, control decode, register file
// with same-cycle writeback bypass and hard-zero XZR, sign extension, reg2 mux,
// load-use hazard detection, and a registered ID/EX slot with valid/ready
// handshake and flush.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - id_stage_pipe_if.slave (fetch handshake, writeback, EX control,
//           ID/EX outputs)
module id_stage_pipe #(
  parameter int WORD      = 64,
  parameter int INSTR_LEN = 32,
  parameter int NUM_REGS  = 32,
  parameter int ZERO_REG  = 31
) (
  input logic          clk,
  input logic          rst_n,
  id_stage_pipe_if.slave bus
);

  localparam int         AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [4:0] ZR = 5'(ZERO_REG);
  localparam logic [5:0] NR = 6'(NUM_REGS);

  typedef struct packed {
    logic       reg2_loc;
    logic       uncondbranch;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  // ---------------- field parse ----------------
  logic [10:0] opc;
  logic [4:0]  rm, rn, rd, idx2;
  assign opc = bus.instruction[INSTR_LEN-1 -: 11];
  assign rm  = bus.instruction[20:16];
  assign rn  = bus.instruction[9:5];
  assign rd  = bus.instruction[4:0];

  // ---------------- control + immediate ----------------
  ctrl_t           ctrl_d;
  logic [WORD-1:0] imm_d;
  logic            uses2;  // instruction reads the second register port

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    ctrl_d = '0;
    imm_d  = '0;
    uses2  = 1'b0;
    casez (opc)
      11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_op    = 2'b10;
        uses2            = 1'b1;
      end
      11'b11111000010: begin  // LDUR
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        imm_d = {{(WORD-9){bus.instruction[20]}}, bus.instruction[20:12]};
      end
      11'b11111000000: begin  // STUR
        ctrl_d.reg2_loc  = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        ctrl_d.mem_write = 1'b1;
        uses2            = 1'b1;
        imm_d = {{(WORD-9){bus.instruction[20]}}, bus.instruction[20:12]};
      end
      11'b10110100???: begin  // CBZ
        ctrl_d.reg2_loc = 1'b1;
        ctrl_d.branch   = 1'b1;
        ctrl_d.alu_op   = 2'b01;
        uses2           = 1'b1;
        imm_d = {{(WORD-19){bus.instruction[23]}}, bus.instruction[23:5]};
      end
      11'b000101?????: begin  // B
        ctrl_d.uncondbranch = 1'b1;
        imm_d = {{(WORD-26){bus.instruction[25]}}, bus.instruction[25:0]};
      end
      default: ;
    endcase
  end

  assign idx2 = ctrl_d.reg2_loc ? rd : rm;

  // ---------------- register file ----------------
  logic [WORD-1:0] regs_q [NUM_REGS];
  logic            wb_ok;
  logic [WORD-1:0] rdata1, rdata2;

  // Writes to XZR or to indices beyond the file are dropped, and must not be
  // forwarded either.
  assign wb_ok = bus.wb_en && (bus.wb_reg != ZR) && ({1'b0, bus.wb_reg} < NR);

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rn != ZR && {1'b0, rn} < NR)
      rdata1 = (wb_ok && bus.wb_reg == rn) ? bus.wb_data : regs_q[rn[AW-1:0]];
    if (idx2 != ZR && {1'b0, idx2} < NR)
      rdata2 = (wb_ok && bus.wb_reg == idx2) ? bus.wb_data : regs_q[idx2[AW-1:0]];
  end

  // NOTE: the register array is cleared on reset because the architecture
  // requires all registers to read zero afterwards; this forces flops rather
  // than a RAM macro, which is fine at 32 entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (wb_ok) begin
      regs_q[bus.wb_reg[AW-1:0]] <= bus.wb_data;
    end
  end

  // ---------------- ID/EX slot ----------------
  logic            out_valid_q;
  ctrl_t           ctrl_q;
  logic [10:0]     opcode_q;
  logic [4:0]      rd_q, rn_q, rm_q;
  logic [WORD-1:0] rd1_q, rd2_q, imm_q;
  logic            hazard, load, in_ready, accept;

  // Load-use: the load in ID/EX has not produced its data yet, so an
  // instruction reading its destination must wait one cycle.
  assign hazard = out_valid_q && ctrl_q.mem_read && (rd_q != ZR) && bus.in_valid &&
                  ((rd_q == rn) || (uses2 && rd_q == idx2));
  assign load     = !out_valid_q || bus.ex_ready;
  assign in_ready = load && !hazard && !bus.flush;
  assign accept   = bus.in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      opcode_q    <= '0;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      rd1_q       <= '0;
      rd2_q       <= '0;
      imm_q       <= '0;
    end else if (bus.flush) begin
      out_valid_q <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= ctrl_d;
      opcode_q    <= opc;
      rd_q        <= rd;
      rn_q        <= rn;
      rm_q        <= rm;
      rd1_q       <= rdata1;
      rd2_q       <= rdata2;
      imm_q       <= imm_d;
    end else if (load) begin
      out_valid_q <= 1'b0;  // bubble; data fields keep their last values
    end
  end

  // A bubble must never write, access memory or branch.
  ctrl_t ctrl_o;
  assign ctrl_o = out_valid_q ? ctrl_q : '0;

  assign bus.in_ready     = in_ready;
  assign bus.hazard       = hazard;
  assign bus.out_valid    = out_valid_q;
  assign bus.opcode       = opcode_q;
  assign bus.rd_num       = rd_q;
  assign bus.rn_num       = rn_q;
  assign bus.rm_num       = rm_q;
  assign bus.read_data1   = rd1_q;
  assign bus.read_data2   = rd2_q;
  assign bus.imm          = imm_q;
  assign bus.reg2_loc     = ctrl_o.reg2_loc;
  assign bus.uncondbranch = ctrl_o.uncondbranch;
  assign bus.branch       = ctrl_o.branch;
  assign bus.mem_read     = ctrl_o.mem_read;
  assign bus.mem_to_reg   = ctrl_o.mem_to_reg;
  assign bus.mem_write    = ctrl_o.mem_write;
  assign bus.alu_src      = ctrl_o.alu_src;
  assign bus.reg_write    = ctrl_o.reg_write;
  assign bus.alu_op       = ctrl_o.alu_op;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by
// randomized traffic, all checked against a behavioural model of the stage.
// A second instance (WORD=32, NUM_REGS=16) covers the out-of-range index rules.
module tb_id_stage_pipe;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_stage_pipe_if #(.WORD(64), .INSTR_LEN(32)) bus ();
  id_stage_pipe #(.WORD(64), .INSTR_LEN(32), .NUM_REGS(32), .ZERO_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  id_stage_pipe_if #(.WORD(32), .INSTR_LEN(32)) sbus ();
  id_stage_pipe #(.WORD(32), .INSTR_LEN(32), .NUM_REGS(16), .ZERO_REG(31)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- instruction encoders ----------------
  function automatic logic [31:0] enc_r(input logic [10:0] op, input logic [4:0] m,
                                        input logic [4:0] n, input logic [4:0] d);
    return {op, m, 6'd0, n, d};
  endfunction
  function automatic logic [31:0] enc_d(input logic [10:0] op, input logic [8:0] off,
                                        input logic [4:0] n, input logic [4:0] t);
    return {op, off, 2'b00, n, t};
  endfunction
  function automatic logic [31:0] enc_cb(input logic [18:0] off, input logic [4:0] t);
    return {8'b10110100, off, t};
  endfunction
  function automatic logic [31:0] enc_b(input logic [25:0] off);
    return {6'b000101, off};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {K_NOP, K_R, K_LDUR, K_STUR, K_CBZ, K_B} kind_e;

  typedef struct packed {
    logic        r2l, ub, br, mr, m2r, mw, as, rw;
    logic [1:0]  aop;
    logic [10:0] opc;
    logic [4:0]  rd, rn, rm;
    logic [63:0] d1, d2, imm;
  } exp_t;

  logic [63:0] m_regs [32];
  logic        m_valid;
  exp_t        m_out;
  logic        last_haz, last_rdy;

  function automatic kind_e classify(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR) return K_R;
    if (op == OP_LDUR) return K_LDUR;
    if (op == OP_STUR) return K_STUR;
    if (op[10:3] == 8'b10110100) return K_CBZ;
    if (op[10:5] == 6'b000101) return K_B;
    return K_NOP;
  endfunction

  // Architectural read as seen by decode: XZR is zero, a same-cycle write wins.
  function automatic logic [63:0] m_read(input logic [4:0] idx, input logic we,
                                         input logic [4:0] wr, input logic [63:0] wd);
    if (idx == 5'd31) return 64'd0;
    if (we && wr == idx) return wd;
    return m_regs[idx];
  endfunction

  function automatic exp_t build(input logic [31:0] ins, input logic we,
                                 input logic [4:0] wr, input logic [63:0] wd);
    exp_t  e;
    kind_e k;
    e = '0;
    k = classify(ins[31:21]);
    e.opc = ins[31:21];
    e.rd  = ins[4:0];
    e.rn  = ins[9:5];
    e.rm  = ins[20:16];
    case (k)
      K_R:    begin e.rw = 1; e.aop = 2'd2; end
      K_LDUR: begin e.as = 1; e.mr = 1; e.m2r = 1; e.rw = 1; e.imm = $signed(ins[20:12]); end
      K_STUR: begin e.r2l = 1; e.as = 1; e.mw = 1; e.imm = $signed(ins[20:12]); end
      K_CBZ:  begin e.r2l = 1; e.br = 1; e.aop = 2'd1; e.imm = $signed(ins[23:5]); end
      K_B:    begin e.ub = 1; e.imm = $signed(ins[25:0]); end
      default: ;
    endcase
    e.d1 = m_read(e.rn, we, wr, wd);
    e.d2 = m_read(e.r2l ? e.rd : e.rm, we, wr, wd);
    return e;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_out   = '0;
    for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
  endtask

  task automatic check_outputs();
    logic [7:0] ctl_obs, ctl_exp;
    ctl_obs = {bus.reg2_loc, bus.uncondbranch, bus.branch, bus.mem_read,
               bus.mem_to_reg, bus.mem_write, bus.alu_src, bus.reg_write};
    ctl_exp = m_valid ? {m_out.r2l, m_out.ub, m_out.br, m_out.mr,
                         m_out.m2r, m_out.mw, m_out.as, m_out.rw} : 8'd0;
    check("out_valid", bus.out_valid, m_valid);
    check("controls", ctl_obs, ctl_exp);
    check("alu_op", bus.alu_op, m_valid ? m_out.aop : 2'd0);
    if (m_valid) begin
      check("opcode", bus.opcode, m_out.opc);
      check("rd_num", bus.rd_num, m_out.rd);
      check("rn_num", bus.rn_num, m_out.rn);
      check("rm_num", bus.rm_num, m_out.rm);
      check("read_data1", bus.read_data1, m_out.d1);
      check("read_data2", bus.read_data2, m_out.d2);
      check("imm", bus.imm, m_out.imm);
    end
  endtask

  // One clock of stimulus: drive at negedge, check combinational outputs,
  // advance the model, then check the ID/EX outputs after the edge.
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic we,
                     input logic [4:0] wr, input logic [63:0] wd,
                     input logic fl, input logic er);
    kind_e       k;
    logic        uses2, haz, rdy, acc;
    logic [4:0]  i2;
    @(negedge clk);
    bus.in_valid    = iv;
    bus.instruction = ins;
    bus.wb_en       = we;
    bus.wb_reg      = wr;
    bus.wb_data     = wd;
    bus.flush       = fl;
    bus.ex_ready    = er;
    #1;
    k     = classify(ins[31:21]);
    uses2 = (k == K_R) || (k == K_STUR) || (k == K_CBZ);
    i2    = (k == K_STUR || k == K_CBZ) ? ins[4:0] : ins[20:16];
    haz   = m_valid && m_out.mr && (m_out.rd != 5'd31) && iv &&
            ((m_out.rd == ins[9:5]) || (uses2 && m_out.rd == i2));
    rdy   = (!m_valid || er) && !haz && !fl;
    last_haz = bus.hazard;
    last_rdy = bus.in_ready;
    check("hazard", bus.hazard, haz);
    check("in_ready", bus.in_ready, rdy);
    acc = iv && rdy;
    if (fl) m_valid = 1'b0;
    else if (acc) begin m_valid = 1'b1; m_out = build(ins, we, wr, wd); end
    else if (!m_valid || er) m_valid = 1'b0;
    if (we && wr != 5'd31) m_regs[wr] = wd;
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [4:0] pick_reg();
    int r;
    r = $urandom_range(0, 8);
    return (r == 8) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r32;
    int          k;
    r32 = $urandom();
    k   = $urandom_range(0, 8);
    case (k)
      0: return enc_r(OP_ADD, pick_reg(), pick_reg(), pick_reg());
      1: return enc_r(OP_SUB, pick_reg(), pick_reg(), pick_reg());
      2: return enc_r(OP_AND, pick_reg(), pick_reg(), pick_reg());
      3: return enc_r(OP_ORR, pick_reg(), pick_reg(), pick_reg());
      4: return enc_d(OP_LDUR, r32[8:0], pick_reg(), pick_reg());
      5: return enc_d(OP_STUR, r32[8:0], pick_reg(), pick_reg());
      6: return enc_cb(r32[18:0], pick_reg());
      7: return enc_b(r32[25:0]);
      default: return {11'h3FF, r32[20:0]};
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd64;
    rst_n = 1'b0;
    bus.in_valid = 0; bus.instruction = '0; bus.wb_en = 0; bus.wb_reg = '0;
    bus.wb_data = '0; bus.flush = 0; bus.ex_ready = 0;
    sbus.in_valid = 0; sbus.instruction = '0; sbus.wb_en = 0; sbus.wb_reg = '0;
    sbus.wb_data = '0; sbus.flush = 0; sbus.ex_ready = 0;
    model_reset();

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_imm", bus.imm, 64'd0);
    check("rst_read_data1", bus.read_data1, 64'd0);
    check("rst_reg_write", bus.reg_write, 1'b0);
    rst_n = 1'b1;

    // ---- writeback then operand read ----
    cyc(0, 32'd0, 1, 5'd9, 64'h1234, 0, 1);
    cyc(1, enc_r(OP_ADD, 5'd9, 5'd9, 5'd1), 0, 5'd0, 64'd0, 0, 1);
    check("add_rd1", bus.read_data1, 64'h1234);
    check("add_rd2", bus.read_data2, 64'h1234);
    check("add_reg_write", bus.reg_write, 1'b1);
    check("add_alu_op", bus.alu_op, 2'b10);

    // ---- bypass and XZR ----
    cyc(1, enc_r(OP_ORR, 5'd31, 5'd5, 5'd2), 1, 5'd5, 64'hAA, 0, 1);
    check("orr_bypass", bus.read_data1, 64'hAA);
    check("orr_xzr", bus.read_data2, 64'd0);
    cyc(0, 32'd0, 1, 5'd31, 64'hFF, 0, 1);
    cyc(1, enc_r(OP_ADD, 5'd31, 5'd31, 5'd8), 0, 5'd0, 64'd0, 0, 1);
    check("xzr_after_write", bus.read_data1, 64'd0);

    // ---- load-use hazard ----
    cyc(1, enc_d(OP_LDUR, 9'h1F8, 5'd4, 5'd3), 0, 5'd0, 64'd0, 0, 1);
    check("ldur_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFF8);
    check("ldur_mem_read", bus.mem_read, 1'b1);
    cyc(1, enc_r(OP_ADD, 5'd7, 5'd3, 5'd6), 0, 5'd0, 64'd0, 0, 1);
    check("lu_hazard", last_haz, 1'b1);
    check("lu_in_ready", last_rdy, 1'b0);
    check("lu_bubble_valid", bus.out_valid, 1'b0);
    check("lu_bubble_rw", bus.reg_write, 1'b0);
    cyc(1, enc_r(OP_ADD, 5'd7, 5'd3, 5'd6), 0, 5'd0, 64'd0, 0, 1);
    check("lu_accept", bus.out_valid, 1'b1);
    check("lu_accept_rn", bus.rn_num, 5'd3);

    // ---- EX stall ----
    cyc(1, enc_d(OP_STUR, 9'd16, 5'd2, 5'd10), 0, 5'd0, 64'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, enc_r(OP_SUB, 5'd13, 5'd12, 5'd11), 0, 5'd0, 64'd0, 0, 0);
      check("stall_in_ready", last_rdy, 1'b0);
      check("stall_hold", bus.mem_write, 1'b1);
    end
    cyc(1, enc_r(OP_SUB, 5'd13, 5'd12, 5'd11), 0, 5'd0, 64'd0, 0, 1);
    check("stall_release", bus.opcode, OP_SUB);

    // ---- flush and B ----
    cyc(1, enc_cb(19'd4, 5'd1), 0, 5'd0, 64'd0, 1, 1);
    check("flush_valid", bus.out_valid, 1'b0);
    check("flush_in_ready", last_rdy, 1'b0);
    cyc(1, enc_b(26'h3FF_FFFF), 0, 5'd0, 64'd0, 0, 1);
    check("b_imm", bus.imm, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b_uncond", bus.uncondbranch, 1'b1);

    // ---- asynchronous reset during a stall ----
    cyc(1, enc_d(OP_LDUR, 9'd8, 5'd1, 5'd2), 0, 5'd0, 64'd0, 0, 1);
    @(negedge clk);
    bus.in_valid = 0; bus.ex_ready = 0; bus.wb_en = 0; bus.flush = 0;
    #2;
    check("pre_rst_valid", bus.out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 1'b0);
    check("async_rst_mem_read", bus.mem_read, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, enc_r(OP_ADD, 5'd9, 5'd9, 5'd1), 0, 5'd0, 64'd0, 0, 1);
    check("x9_after_reset", bus.read_data1, 64'd0);

    // ---- randomized traffic ----
    for (int n = 0; n < 400; n++) begin
      rd64 = {$urandom(), $urandom()};
      cyc(($urandom_range(0, 9) < 8), rand_instr(), $urandom_range(0, 1),
          5'($urandom_range(0, 31)), rd64, ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 9) < 7));
    end

    // ---- WORD=32, NUM_REGS=16 instance ----
    @(negedge clk);
    bus.in_valid = 0; bus.wb_en = 0; bus.flush = 0;
    sbus.ex_ready = 1; sbus.in_valid = 1;
    sbus.wb_en = 1; sbus.wb_reg = 5'd20; sbus.wb_data = 32'h55;
    sbus.instruction = enc_r(OP_ORR, 5'd20, 5'd20, 5'd2);
    @(posedge clk); #1;
    check("s_valid", sbus.out_valid, 1'b1);
    check("s_no_bypass_x20", sbus.read_data1, 64'd0);
    @(negedge clk);
    sbus.wb_reg = 5'd3; sbus.wb_data = 32'h77;
    sbus.instruction = enc_r(OP_ADD, 5'd3, 5'd20, 5'd1);
    @(posedge clk); #1;
    check("s_x20_ignored", sbus.read_data1, 64'd0);
    check("s_bypass_x3", sbus.read_data2, 64'h77);
    @(negedge clk);
    sbus.wb_en = 0;
    sbus.instruction = enc_r(OP_ADD, 5'd4, 5'd3, 5'd1);
    @(posedge clk); #1;
    check("s_x3_stored", sbus.read_data1, 64'h77);
    @(negedge clk);
    sbus.in_valid = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
